mm2_kernel: RTL and testbench



---
 rtl/mm2_kernel.sv | 211 +++++++++++++++++++++
 tb/tb_mm2_kernel.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2_kernel.sv
// Integer 2MM kernel: tmp = ALPHA*A*B, then D = BETA*D + tmp*C, with all
// operands fetched and results stored one word at a time over a single-outstanding request port.
module mm2_kernel #(
  parameter int unsigned NI    = 4,
  parameter int unsigned NK    = 4,
  parameter int unsigned NJ    = 4,
  parameter int unsigned NL    = 4,
  parameter logic [31:0] ALPHA = 32'd32412,
  parameter logic [31:0] BETA  = 32'd2123
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] read_base,
  input  logic [63:0] write_base,
  input  logic [63:0] num_read,
  input  logic [63:0] read_size_input,
  input  logic [63:0] read_ready,
  input  logic [63:0] write_ready,
  input  logic [31:0] read_data,
  output logic        read_enable,
  output logic        write_enable,
  output logic        finish_read,
  output logic        finish_write,
  output logic        done,
  output logic [63:0] read_addr,
  output logic [63:0] write_addr,
  output logic [63:0] write_size,
  output logic [63:0] read_size_output,
  output logic [31:0] write_data,
  output logic [31:0] returnvalue
);

  localparam int unsigned OFF_B = NI * NK;
  localparam int unsigned OFF_C = OFF_B + NK * NJ;
  localparam int unsigned OFF_D = OFF_C + NJ * NL;
  localparam int unsigned OFF_T = OFF_D + NI * NL;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FIN, S_DONE} state_t;
  typedef enum logic [2:0] {OP_A, OP_B, OP_WT, OP_D, OP_T, OP_C, OP_WD} op_t;

  state_t      r_state, w_next;
  op_t         r_op;
  logic [31:0] r_i, r_j, r_k, r_l;
  logic [31:0] r_acc, r_opa, r_rdata;
  logic [31:0] w_off, w_prod, w_sum_ab, w_sum_tc;
  logic [63:0] w_addr;
  logic        w_is_wr, w_ack, w_last_i, w_last_j, w_last_k, w_last_l, w_final;
  logic        w_unused;

  assign w_unused = ^{write_base, num_read, read_ready[63:1], write_ready[63:1]};

  assign write_size       = read_size_input;
  assign read_size_output = read_size_input;
  assign returnvalue      = '0;

  assign w_is_wr  = (r_op == OP_WT) || (r_op == OP_WD);
  assign w_ack    = w_is_wr ? write_ready[0] : read_ready[0];
  assign w_last_i = (r_i == NI - 1);
  assign w_last_j = (r_j == NJ - 1);
  assign w_last_k = (r_k == NK - 1);
  assign w_last_l = (r_l == NL - 1);
  assign w_final  = (r_op == OP_WD) && w_last_i && w_last_l;

  assign w_prod   = r_opa * r_rdata;
  assign w_sum_ab = r_acc + ALPHA * w_prod;
  assign w_sum_tc = r_acc + w_prod;

  // Word offset of the element the current operation touches.
  always_comb begin
    w_off = '0;
    unique case (r_op)
      OP_A:         w_off = r_i * NK + r_k;
      OP_B:         w_off = OFF_B + r_k * NJ + r_j;
      OP_WT, OP_T:  w_off = OFF_T + r_i * NJ + r_j;
      OP_D, OP_WD:  w_off = OFF_D + r_i * NL + r_l;
      OP_C:         w_off = OFF_C + r_j * NL + r_l;
      default:      w_off = '0;
    endcase
  end

  assign w_addr = read_base + {30'b0, w_off, 2'b00};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (w_ack) w_next = S_FIN;
      S_FIN:   w_next = w_final ? S_DONE : S_REQ;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= OP_A;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_l          <= '0;
      r_acc        <= '0;
      r_opa        <= '0;
      r_rdata      <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      finish_read  <= 1'b0;
      finish_write <= 1'b0;
      done         <= 1'b0;
      read_addr    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_is_wr) begin
            write_enable <= 1'b1;
            write_addr   <= w_addr;
            write_data   <= r_acc;
          end else begin
            read_enable <= 1'b1;
            read_addr   <= w_addr;
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            if (w_is_wr) begin
              write_enable <= 1'b0;
              finish_write <= 1'b1;
              if (w_final) done <= 1'b1;
            end else begin
              read_enable <= 1'b0;
              finish_read <= 1'b1;
              r_rdata     <= read_data;
            end
          end
        end
        // Finish-pulse cycle doubles as the compute/index-advance step.
        S_FIN: begin
          finish_read  <= 1'b0;
          finish_write <= 1'b0;
          unique case (r_op)
            OP_A: begin
              r_opa <= r_rdata;
              r_op  <= OP_B;
            end
            OP_B: begin
              r_acc <= w_sum_ab;
              if (w_last_k) begin
                r_k  <= '0;
                r_op <= OP_WT;
              end else begin
                r_k  <= r_k + 1;
                r_op <= OP_A;
              end
            end
            OP_WT: begin
              r_acc <= '0;
              r_op  <= OP_A;
              if (w_last_j) begin
                r_j <= '0;
                if (w_last_i) begin
                  r_i  <= '0;
                  r_op <= OP_D;
                end else begin
                  r_i <= r_i + 1;
                end
              end else begin
                r_j <= r_j + 1;
              end
            end
            OP_D: begin
              r_acc <= BETA * r_rdata;
              r_op  <= OP_T;
            end
            OP_T: begin
              r_opa <= r_rdata;
              r_op  <= OP_C;
            end
            OP_C: begin
              r_acc <= w_sum_tc;
              if (w_last_j) begin
                r_j  <= '0;
                r_op <= OP_WD;
              end else begin
                r_j  <= r_j + 1;
                r_op <= OP_T;
              end
            end
            OP_WD: begin
              r_op <= OP_D;
              if (w_last_l) begin
                r_l <= '0;
                if (!w_last_i) r_i <= r_i + 1;
              end else begin
                r_l <= r_l + 1;
              end
            end
            default: r_op <= OP_A;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm2_kernel.sv
// Randomized bench for mm2_kernel: a memory responder serves requests and a
// loop-level model of the 2MM kernel predicts every access and written value.
module tb_mm2_kernel;
  localparam int unsigned NI = 4, NK = 4, NJ = 4, NL = 4;
  localparam logic [31:0] ALPHA = 32'd32412, BETA = 32'd2123;
  localparam int unsigned MW = NI*NK + NK*NJ + NJ*NL + NI*NL + NI*NJ;

  logic        clk = 1'b0;
  logic        rst_main = 1'b1, rst_abort = 1'b0;
  logic        reset;
  logic [63:0] read_base = '0, write_base = '0, num_read = '0, read_size_input = '0;
  logic [63:0] read_ready = '0, write_ready = '0;
  logic [31:0] read_data = '0;
  logic        read_enable, write_enable, finish_read, finish_write, done;
  logic [63:0] read_addr, write_addr, write_size, read_size_output;
  logic [31:0] write_data, returnvalue;

  assign reset = rst_main | rst_abort;
  always #5 clk = ~clk;

  mm2_kernel #(.NI(NI), .NK(NK), .NJ(NJ), .NL(NL), .ALPHA(ALPHA), .BETA(BETA)) dut (
    .clk(clk), .reset(reset), .read_base(read_base), .write_base(write_base),
    .num_read(num_read), .read_size_input(read_size_input), .read_ready(read_ready),
    .write_ready(write_ready), .read_data(read_data), .read_enable(read_enable),
    .write_enable(write_enable), .finish_read(finish_read), .finish_write(finish_write),
    .done(done), .read_addr(read_addr), .write_addr(write_addr), .write_size(write_size),
    .read_size_output(read_size_output), .write_data(write_data), .returnvalue(returnvalue)
  );

  int unsigned n_vec = 0, n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct { bit wr; int unsigned off; logic [31:0] data; } acc_t;
  acc_t        exp_q[$];
  logic [31:0] mm[0:127];
  logic [31:0] mem[0:MW-1];

  function automatic void push(bit wr, int unsigned off, logic [31:0] data);
    acc_t e;
    e.wr = wr; e.off = off; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Straight transcription of the two loop nests over the word array mm.
  function automatic void build_model(int unsigned ni, int unsigned nk, int unsigned nj,
                                      int unsigned nl, logic [31:0] al, logic [31:0] be);
    int unsigned ob, oc, od, ot;
    logic [31:0] acc;
    ob = ni*nk; oc = ob + nk*nj; od = oc + nj*nl; ot = od + ni*nl;
    exp_q.delete();
    for (int unsigned i = 0; i < ni; i++)
      for (int unsigned j = 0; j < nj; j++) begin
        acc = 0;
        for (int unsigned k = 0; k < nk; k++) begin
          push(0, i*nk + k, mm[i*nk + k]);
          push(0, ob + k*nj + j, mm[ob + k*nj + j]);
          acc = acc + al * mm[i*nk + k] * mm[ob + k*nj + j];
        end
        mm[ot + i*nj + j] = acc;
        push(1, ot + i*nj + j, acc);
      end
    for (int unsigned i = 0; i < ni; i++)
      for (int unsigned l = 0; l < nl; l++) begin
        push(0, od + i*nl + l, mm[od + i*nl + l]);
        acc = be * mm[od + i*nl + l];
        for (int unsigned j = 0; j < nj; j++) begin
          push(0, ot + i*nj + j, mm[ot + i*nj + j]);
          push(0, oc + j*nl + l, mm[oc + j*nl + l]);
          acc = acc + mm[ot + i*nj + j] * mm[oc + j*nl + l];
        end
        mm[od + i*nl + l] = acc;
        push(1, od + i*nl + l, acc);
      end
  endfunction

  function automatic int unsigned count_q(bit wr);
    int unsigned n = 0;
    foreach (exp_q[q]) if (exp_q[q].wr == wr) n++;
    return n;
  endfunction

  function automatic void load_model_from_mem();
    for (int w = 0; w < 128; w++) mm[w] = (w < int'(MW)) ? mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] pick_data();
    logic [31:0] sp[5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  int unsigned wo[8] = '{16, 17, 18, 19, 12, 13, 14, 15};
  logic [31:0] wd[8] = '{1, 2, 3, 4, 3, 3, 7, 7};

  int unsigned lat_max = 3, abort_at = 0, cur_run = 0;
  bit          run_done = 0;

  // Responder + scoreboard: one compare point per DUT request and per cycle.
  acc_t        e;
  bit          is_rd, prev_fin = 0;
  logic [63:0] addr;
  int unsigned reads_seen = 0, rd_idx = 0, wr_idx = 0, lat;

  initial begin
    forever begin
      @(negedge clk);
      read_ready = '0;
      write_ready = '0;
      if (reset) begin
        prev_fin = 0;
        continue;
      end
      chk("no_dual_request", {63'b0, read_enable & write_enable}, 64'h0);
      if (prev_fin) begin
        chk("finish_read_one_cycle", {63'b0, finish_read}, 64'h0);
        chk("finish_write_one_cycle", {63'b0, finish_write}, 64'h0);
        prev_fin = 0;
      end
      if (!(read_enable || write_enable)) begin
        if (!run_done && $urandom_range(0, 7) == 0) read_ready = 64'h1;
        else if (!run_done && $urandom_range(0, 7) == 0) write_ready = 64'h1;
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("extra_request", {62'b0, read_enable, write_enable}, 64'h0);
        continue;
      end
      if (read_enable && abort_at != 0 && reads_seen == abort_at) begin
        rst_abort = 1'b1;
        #1;
        chk("abort_read_enable", {63'b0, read_enable}, 64'h0);
        chk("abort_write_enable", {63'b0, write_enable}, 64'h0);
        chk("abort_done", {63'b0, done}, 64'h0);
        chk("abort_read_addr", read_addr, 64'h0);
        chk("abort_write_addr", write_addr, 64'h0);
        chk("abort_write_data", {32'b0, write_data}, 64'h0);
        chk("abort_finish", {62'b0, finish_read, finish_write}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        load_model_from_mem();
        build_model(NI, NK, NJ, NL, ALPHA, BETA);
        abort_at = 0; reads_seen = 0; rd_idx = 0; wr_idx = 0;
        rst_abort = 1'b0;
        continue;
      end
      e = exp_q.pop_front();
      is_rd = read_enable;
      addr = is_rd ? read_addr : write_addr;
      chk("request_kind", {63'b0, write_enable}, {63'b0, e.wr});
      chk("request_addr", addr, read_base + 64'(e.off) * 4);
      if (is_rd) begin
        if (rd_idx == 0) chk("first_read_addr", read_addr, read_base);
        if (rd_idx == 1 && cur_run == 0) chk("second_read_addr", read_addr, read_base + 64'h40);
        rd_idx++;
      end else begin
        if (wr_idx == 0 && cur_run == 0) chk("first_write_addr", write_addr, read_base + 64'h100);
        wr_idx++;
        chk("write_data", {32'b0, write_data}, {32'b0, e.data});
      end
      lat = (lat_max >= 10) ? lat_max : $urandom_range(0, lat_max);
      repeat (lat) begin
        @(negedge clk);
        chk("hold_enable", {63'b0, is_rd ? read_enable : write_enable}, 64'h1);
        chk("hold_addr", is_rd ? read_addr : write_addr, addr);
        chk("no_early_finish", {62'b0, finish_read, finish_write}, 64'h0);
      end
      if (is_rd) begin
        read_data = mem[e.off];
        read_ready = 64'h1;
        reads_seen++;
      end else begin
        mem[e.off] = write_data;
        write_ready = 64'h1;
      end
      @(negedge clk);
      read_ready = '0;
      write_ready = '0;
      read_data = $urandom;
      chk("finish_pulse", {63'b0, is_rd ? finish_read : finish_write}, 64'h1);
      chk("enable_dropped", {63'b0, is_rd ? read_enable : write_enable}, 64'h0);
      prev_fin = 1;
      if (exp_q.size() == 0) begin
        chk("done_after_last_write", {63'b0, done}, 64'h1);
        run_done = 1;
      end else begin
        chk("done_not_early", {63'b0, done}, 64'h0);
      end
    end
  end

  initial begin
    int unsigned wi;
    // Hand-computed cases that pin the model: 2x2 basic and 32-bit overflow.
    for (int w = 0; w < 128; w++) mm[w] = '0;
    mm[0] = 1; mm[1] = 2; mm[2] = 3; mm[3] = 4;
    mm[4] = 1; mm[7] = 1;
    for (int w = 8; w < 12; w++) mm[w] = 1;
    build_model(2, 2, 2, 2, 32'd1, 32'd1);
    chk("model_basic_reads", 64'(count_q(0)), 64'd36);
    chk("model_basic_writes", 64'(count_q(1)), 64'd8);
    chk("model_first_read_off", 64'(exp_q[0].off), 64'd0);
    chk("model_second_read_off", 64'(exp_q[1].off), 64'd4);
    wi = 0;
    foreach (exp_q[q]) if (exp_q[q].wr) begin
      if (wi < 8) begin
        chk("model_basic_woff", 64'(exp_q[q].off), 64'(wo[wi]));
        chk("model_basic_wdata", {32'b0, exp_q[q].data}, {32'b0, wd[wi]});
      end
      wi++;
    end
    for (int w = 0; w < 128; w++) mm[w] = '0;
    mm[0] = 32'h0001_0000; mm[4] = 32'h0001_0000;
    build_model(2, 2, 2, 2, 32'd1, 32'd1);
    foreach (exp_q[q]) if (exp_q[q].wr && exp_q[q].off == 16)
      chk("model_overflow_tmp00", {32'b0, exp_q[q].data}, 64'h0);
    build_model(NI, NK, NJ, NL, ALPHA, BETA);
    chk("model_default_reads", 64'(count_q(0)), 64'd272);
    chk("model_default_writes", 64'(count_q(1)), 64'd32);

    // Run 0: fast random latency; run 1: 10-cycle latency; run 2: reset during phase 2.
    for (int unsigned r = 0; r < 3; r++) begin
      rst_main = 1'b1;
      cur_run = r;
      lat_max = (r == 1) ? 10 : 3;
      abort_at = (r == 2) ? 150 : 0;
      read_base = (r == 0) ? 64'h1000 : {32'($urandom), 32'($urandom) & 32'hFFFF_F000};
      read_size_input = {32'($urandom), 32'($urandom)};
      for (int w = 0; w < int'(MW); w++) mem[w] = pick_data();
      load_model_from_mem();
      build_model(NI, NK, NJ, NL, ALPHA, BETA);
      reads_seen = 0; rd_idx = 0; wr_idx = 0; run_done = 0;
      repeat (3) @(negedge clk);
      chk("reset_read_enable", {63'b0, read_enable}, 64'h0);
      chk("reset_write_enable", {63'b0, write_enable}, 64'h0);
      chk("reset_done", {63'b0, done}, 64'h0);
      chk("reset_read_addr", read_addr, 64'h0);
      chk("reset_write_addr", write_addr, 64'h0);
      chk("reset_write_data", {32'b0, write_data}, 64'h0);
      chk("reset_returnvalue", {32'b0, returnvalue}, 64'h0);
      chk("write_size_passthru", write_size, read_size_input);
      chk("read_size_passthru", read_size_output, read_size_input);
      rst_main = 1'b0;
      for (int c = 0; c < 15000 && !run_done; c++) @(negedge clk);
      chk("run_completed", {63'b0, run_done}, 64'h1);
      if (run_done) begin
        repeat (20) begin
          @(negedge clk);
          chk("idle_after_done", {62'b0, read_enable, write_enable}, 64'h0);
          chk("done_holds", {63'b0, done}, 64'h1);
        end
      end
      chk("all_accesses_seen", 64'(exp_q.size()), 64'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
